scaler_tick_scheduler: RTL

- Turns scaler stage outputs (FS02..FS17 levels) into periodic counter-increment requests.
- Up to NCH channels (TIME1/3/4/6-style timers); each is programmed with one scaler stage.
- Rising edges of a channel's stage become pending requests.
- Pending requests are arbitrated one at a time onto the shared counter-increment (CINC) handshake toward the priority-counter logic.

---
 rtl/scaler_sched_pkg.sv | 19 +
 rtl/scaler_sched_arb.sv | 47 ++++
 rtl/scaler_tick_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/scaler_sched_pkg.sv
// Shared types and default sizing for the scaler tick scheduler.
// Build option: SCALER_SCHED_RR_EN selects round-robin arbitration
// instead of fixed lowest-index priority.
package scaler_sched_pkg;

    localparam int NCH_DEF    = 4;
    localparam int NSTAGE_DEF = 16;
    localparam int SELW_DEF   = 4;
    localparam int CHW        = $clog2(NCH_DEF);

    // Handshake sequencer states. GAP forces CINC_REQ low for one cycle
    // between consecutive grants.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/scaler_sched_arb.sv
// Combinational winner selection among pending channels.
// Build option: SCALER_SCHED_RR_EN -- search starts one past the last
// granted channel (ptr_i); otherwise the lowest pending index wins.
module scaler_sched_arb
    import scaler_sched_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0]  req_i,
`ifdef SCALER_SCHED_RR_EN
    input  logic [CH_W-1:0] ptr_i,
`endif
    output logic [CH_W-1:0] grant_o,
    output logic            valid_o
);

`ifdef SCALER_SCHED_RR_EN
    // Rotating search: first pending channel after the pointer wins.
    always_comb begin
        int unsigned idx;
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(ptr_i) + 1 + i) % NCH;
            if (!valid_o && req_i[idx]) begin
                valid_o = 1'b1;
                grant_o = CH_W'(idx);
            end
        end
    end
`else
    // Fixed priority: scan from the top so the lowest index is written last.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                grant_o = CH_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/scaler_tick_scheduler.sv
// Scaler tick scheduler: converts rising edges of selected scaler stages
// into pending per-channel requests and serves them one at a time on the
// CINC_REQ/CINC_ACK handshake.
// Build option: SCALER_SCHED_RR_EN enables round-robin arbitration with a
// last-grant pointer; without it, lowest channel index wins.
module scaler_tick_scheduler
    import scaler_sched_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int SELW   = SELW_DEF,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              SIM_CLK,
    input  logic              RESET_,
    input  logic [NSTAGE-1:0] FS_IN,
    input  logic              CFG_WE,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [SELW-1:0]   CFG_STAGE,
    input  logic              CFG_EN,
    output logic              CINC_REQ,
    output logic [CH_W-1:0]   CINC_CH,
    input  logic              CINC_ACK,
    output logic [NCH-1:0]    MISS,
    input  logic              MISS_CLR,
    output logic [NCH-1:0]    PEND
);

    state_e            state_q, state_d;
    logic [NSTAGE-1:0] prev_fs_q;
    logic [NSTAGE-1:0] ev;
    logic [NCH-1:0]    en_q;
    logic [SELW-1:0]   sel_q [NCH];
    logic [NCH-1:0]    pend_q, pend_d;
    logic [NCH-1:0]    miss_q, miss_d;
    logic [NCH-1:0]    ch_ev;
    logic [NCH-1:0]    cfg_hit;
    logic [NCH-1:0]    grant_clr;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   win;
    logic              win_valid;
    logic              grant_take;

    // Stage history starts at all ones so stages already high out of reset
    // do not look like fresh edges.
    always_ff @(posedge SIM_CLK or negedge RESET_) begin
        if (!RESET_) prev_fs_q <= '1;
        else         prev_fs_q <= FS_IN;
    end

    // Edges are detected on the global stage vector; a channel just picks one
    // bit, so re-selecting a stage can never fabricate an edge.
    assign ev = FS_IN & ~prev_fs_q;

    // A grant is taken whenever IDLE sees any pending channel.
    assign grant_take = (state_q == ST_IDLE) && win_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign cfg_hit[gi]   = CFG_WE && (CFG_CH == CH_W'(gi));
            assign ch_ev[gi]     = en_q[gi] & ev[sel_q[gi]];
            assign grant_clr[gi] = grant_take && (win == CH_W'(gi));

            // New event beats a same-cycle grant clear; a config write or a
            // disabled channel forces the pending bit low.
            assign pend_d[gi] = ~cfg_hit[gi] & en_q[gi]
                              & ((pend_q[gi] & ~grant_clr[gi]) | ch_ev[gi]);

            // A miss is an event landing on a request that stays pending;
            // setting beats clearing.
            assign miss_d[gi] = (miss_q[gi] & ~MISS_CLR)
                              | (ch_ev[gi] & pend_q[gi] & ~grant_clr[gi] & ~cfg_hit[gi]);

            // Per-channel configuration written by the config strobe.
            always_ff @(posedge SIM_CLK or negedge RESET_) begin
                if (!RESET_) begin
                    en_q[gi]  <= 1'b0;
                    sel_q[gi] <= '0;
                end else if (cfg_hit[gi]) begin
                    en_q[gi]  <= CFG_EN;
                    sel_q[gi] <= CFG_STAGE;
                end
            end
        end
    endgenerate

    // Pending and sticky miss vectors.
    always_ff @(posedge SIM_CLK or negedge RESET_) begin
        if (!RESET_) begin
            pend_q <= '0;
            miss_q <= '0;
        end else begin
            pend_q <= pend_d;
            miss_q <= miss_d;
        end
    end

`ifdef SCALER_SCHED_RR_EN
    logic [CH_W-1:0] ptr_q;

    // Last-granted pointer; starting at NCH-1 makes channel 0 first after reset.
    always_ff @(posedge SIM_CLK or negedge RESET_) begin
        if (!RESET_)         ptr_q <= CH_W'(NCH - 1);
        else if (grant_take) ptr_q <= win;
    end

    scaler_sched_arb #(.NCH(NCH), .CH_W(CH_W)) u_arb (
        .req_i   (pend_q),
        .ptr_i   (ptr_q),
        .grant_o (win),
        .valid_o (win_valid)
    );
`else
    scaler_sched_arb #(.NCH(NCH), .CH_W(CH_W)) u_arb (
        .req_i   (pend_q),
        .grant_o (win),
        .valid_o (win_valid)
    );
`endif

    // Served channel is latched on entry to REQ and held until acknowledged.
    always_ff @(posedge SIM_CLK or negedge RESET_) begin
        if (!RESET_)         ch_q <= '0;
        else if (grant_take) ch_q <= win;
    end

    // Handshake state register.
    always_ff @(posedge SIM_CLK or negedge RESET_) begin
        if (!RESET_) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: wait for pending work, wait for ack (no timeout), one gap cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (win_valid) state_d = ST_REQ;
            ST_REQ:  if (CINC_ACK)  state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state so reset drops REQ immediately.
    always_comb begin
        CINC_REQ = (state_q == ST_REQ);
        CINC_CH  = ch_q;
        PEND     = pend_q;
        MISS     = miss_q;
    end

endmodule
